// File: rtl/seg7_scan_drv.sv
// ---------------------------------------------------------------------------
// seg7_scan_drv
//
// Drives a 4-digit multiplexed common-anode 7-segment display with a 16-bit
// hex value. Digits are time-multiplexed, with one digit per slot of
// DIV_MAX+1 clocks. Each slot starts with BLANK_CYCLES clocks where every
// anode is off, so the segment lines can settle before the next digit lights.
// The displayed value is captured once per frame, at the end of digit 3's
// slot. A change to the input in the middle of a frame therefore never mixes
// two values on the display.
//
// Build option:
//   SEG_LZB_EN  leading-zero blanking. When defined, digit k (k = 3..1) is
//               held dark when shadow nibbles k..3 are all zero and the
//               captured decimal point for that digit is clear. Digit 0 is
//               always shown.
//
// Ports:
//   clk     in   1   system clock
//   clr     in   1   asynchronous active-high reset
//   value   in   16  value[3:0] -> digit 0 (rightmost) ... value[15:12] -> digit 3
//   dp_in   in   4   decimal point request per digit, active-high
//   en      in   1   display enable; 0 forces all anodes off, scan keeps running
//   an      out  4   digit anodes, active-low
//   seg     out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp      out  1   decimal point, active-low
// ---------------------------------------------------------------------------
module seg7_scan_drv #(
    parameter int          DIV_WIDTH    = 17,
    parameter int unsigned DIV_MAX      = 49999,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [DIV_WIDTH-1:0] CNT_MAX   = DIV_WIDTH'(DIV_MAX);
    localparam logic [DIV_WIDTH-1:0] CNT_BLANK = DIV_WIDTH'(BLANK_CYCLES);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE   = DIV_WIDTH'(1);

    // Scan state
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;

    // Per-frame snapshot of the display contents
    logic [15:0]          shadow_q, shadow_d;
    logic [3:0]           dp_sh_q, dp_sh_d;

    // Registered pad outputs
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;

    // Combinational helpers
    logic                 cnt_wrap;
    logic                 frame_end;
    logic [3:0]           cur_nibble;
    logic [3:0]           suppress;
    logic                 digit_lit;

    // Hex to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Refresh counter and digit index
    always_comb begin
        cnt_wrap = (cnt_q == CNT_MAX);
        cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_ONE;
        idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;
    end

    // The frame boundary is the last clock of digit 3's slot. Capturing the
    // snapshot here makes it valid in the same clock that digit 0's slot starts.
    always_comb begin
        frame_end = cnt_wrap && (idx_q == 2'd3);
        shadow_d  = frame_end ? value : shadow_q;
        dp_sh_d   = frame_end ? dp_in : dp_sh_q;
    end

    // Select the nibble for the current digit
    always_comb begin
        cur_nibble = 4'h0;
        case (idx_q)
            2'd0:    cur_nibble = shadow_q[3:0];
            2'd1:    cur_nibble = shadow_q[7:4];
            2'd2:    cur_nibble = shadow_q[11:8];
            default: cur_nibble = shadow_q[15:12];
        endcase
    end

    // Digit suppression is derived only from the snapshot, so it cannot change
    // during a frame.
    always_comb begin
        suppress = 4'b0000;
`ifdef SEG_LZB_EN
        suppress[3] = (shadow_q[15:12] == 4'h0) && !dp_sh_q[3];
        suppress[2] = (shadow_q[15:8]  == 8'h00) && !dp_sh_q[2];
        suppress[1] = (shadow_q[15:4]  == 12'h000) && !dp_sh_q[1];
        suppress[0] = 1'b0;
`else
        suppress    = 4'b0000;
`endif
    end

    // Output stage. seg and dp follow the index with no gating, so they change
    // at the slot start. The anode stays off until the blank window has passed.
    always_comb begin
        digit_lit = en && (cnt_q >= CNT_BLANK) && !suppress[idx_q];
        an_d      = digit_lit ? ~(4'b0001 << idx_q) : 4'b1111;
        seg_d     = hex_to_seg(cur_nibble);
        dp_d      = ~dp_sh_q[idx_q];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            shadow_q <= 16'h0000;
            dp_sh_q  <= 4'b0000;
            an_q     <= 4'b1111;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            dp_sh_q  <= dp_sh_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
